// File: rtl/seg_scan_if.sv
// seg_scan_if: load/data inputs and display pin outputs of the 7-segment scan driver
interface seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;
  modport master (output load, digits, dp_in, blank, input seg_n, dp_n, an_n, frame_done);
  modport slave  (input load, digits, dp_in, blank, output seg_n, dp_n, an_n, frame_done);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment driver, frame-synchronous double buffering
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int DEAD       = 2,
  parameter bit HEX_EN     = 1'b1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  seg_scan_if.slave io_disp
);
  localparam int CW = $clog2(DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_stg_dig, r_act_dig;
  logic [NUM_DIGITS-1:0]   r_stg_dp, r_stg_bl, r_act_dp, r_act_bl;
  logic                    r_pend, r_live;
  logic [6:0]              r_seg_n;
  logic                    r_dp_n, r_fd;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    w_slot_wrap, w_frame_wrap, w_commit, w_live_nx;
  logic [CW-1:0]           w_cnt_nx;
  logic [IW-1:0]           w_idx_nx;
  logic [4*NUM_DIGITS-1:0] w_act_dig_nx;
  logic [NUM_DIGITS-1:0]   w_act_dp_nx, w_act_bl_nx, w_an_n;
  logic [3:0]              w_code;
  logic                    w_dp, w_bl;
  logic [6:0]              w_seg_n;
  assign w_slot_wrap  = r_cnt == CW'(DIV - 1);
  assign w_frame_wrap = w_slot_wrap && r_idx == IW'(NUM_DIGITS - 1);
  assign w_cnt_nx     = w_slot_wrap ? '0 : r_cnt + CW'(1);
  assign w_idx_nx     = w_frame_wrap ? '0 : w_slot_wrap ? r_idx + IW'(1) : r_idx;
  // a load coinciding with the wrap bypasses staging so it is shown one cycle later
  assign w_commit     = w_frame_wrap && (io_disp.load || r_pend);
  assign w_act_dig_nx = !w_commit ? r_act_dig : io_disp.load ? io_disp.digits : r_stg_dig;
  assign w_act_dp_nx  = !w_commit ? r_act_dp  : io_disp.load ? io_disp.dp_in  : r_stg_dp;
  assign w_act_bl_nx  = !w_commit ? r_act_bl  : io_disp.load ? io_disp.blank  : r_stg_bl;
  assign w_live_nx    = r_live || w_commit;
  always_comb begin
    w_code = '0;
    w_dp   = 1'b0;
    w_bl   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_idx_nx == IW'(i)) begin
        w_code = w_act_dig_nx[4*i +: 4];
        w_dp   = w_act_dp_nx[i];
        w_bl   = w_act_bl_nx[i];
      end
  end
  assign w_seg_n = (w_bl || (w_code > 4'd9 && !HEX_EN)) ? 7'h7F : SEG[w_code];
  // anodes stay dark until the first commit, and during the dead band of every slot
  assign w_an_n  = (!w_live_nx || int'(w_cnt_nx) < DEAD) ? '1 : ~(NUM_DIGITS'(1) << w_idx_nx);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_live    <= 1'b0;
      r_stg_dig <= '0;
      r_stg_dp  <= '0;
      r_stg_bl  <= '1;
      r_act_dig <= '0;
      r_act_dp  <= '0;
      r_act_bl  <= '1;
      r_seg_n   <= 7'h7F;
      r_dp_n    <= 1'b1;
      r_an_n    <= '1;
      r_fd      <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nx;
      r_idx     <= w_idx_nx;
      r_pend    <= w_frame_wrap ? 1'b0 : (r_pend || io_disp.load);
      r_live    <= w_live_nx;
      r_act_dig <= w_act_dig_nx;
      r_act_dp  <= w_act_dp_nx;
      r_act_bl  <= w_act_bl_nx;
      if (io_disp.load) begin
        r_stg_dig <= io_disp.digits;
        r_stg_dp  <= io_disp.dp_in;
        r_stg_bl  <= io_disp.blank;
      end
      r_seg_n   <= w_seg_n;
      r_dp_n    <= w_bl || !w_dp;
      r_an_n    <= w_an_n;
      r_fd      <= w_frame_wrap;
    end
  assign io_disp.seg_n      = r_seg_n;
  assign io_disp.dp_n       = r_dp_n;
  assign io_disp.an_n       = r_an_n;
  assign io_disp.frame_done = r_fd;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench, hex and decimal 4-digit drivers plus a 1-digit DIV=2 driver
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  seg_scan_if #(4) ia ();
  seg_scan_if #(4) ib ();
  seg_scan_if #(1) ic ();
  seg_scan_driver #(.NUM_DIGITS(4), .DIV(4), .DEAD(1), .HEX_EN(1'b1)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_disp(ia));
  seg_scan_driver #(.NUM_DIGITS(4), .DIV(4), .DEAD(1), .HEX_EN(1'b0)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_disp(ib));
  seg_scan_driver #(.NUM_DIGITS(1), .DIV(2), .DEAD(0), .HEX_EN(1'b1)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .io_disp(ic));
  typedef struct {
    logic [3:0] an;
    logic [6:0] sa, sb;
    logic       dp, fd;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] seg_tab(input logic [3:0] c, input bit hex);
    case (c)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return hex ? 7'b0001000 : 7'h7F;
      4'hB: return hex ? 7'b1100000 : 7'h7F;
      4'hC: return hex ? 7'b0110001 : 7'h7F;
      4'hD: return hex ? 7'b1000010 : 7'h7F;
      4'hE: return hex ? 7'b0110000 : 7'h7F;
      default: return hex ? 7'b0111000 : 7'h7F;
    endcase
  endfunction
  task automatic drive(input logic l, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    ia.load = l; ia.digits = d; ia.dp_in = dp; ia.blank = bl;
    ib.load = l; ib.digits = d; ib.dp_in = dp; ib.blank = bl;
    ic.load = l; ic.digits = d[3:0]; ic.dp_in = dp[0]; ic.blank = bl[0];
  endtask
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      int s;
      logic [3:0] code;
      s = k / 4;
      code = d[4*s +: 4];
      e.an = (k % 4 < 1) ? 4'hF : ~(4'b0001 << s);
      e.sa = bl[s] ? 7'h7F : seg_tab(code, 1'b1);
      e.sb = bl[s] ? 7'h7F : seg_tab(code, 1'b0);
      e.dp = bl[s] ? 1'b1 : ~dp[s];
      e.fd = (k == 0);
      q.push_back(e);
    end
  endtask
  task automatic wait_fd();
    logic hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = ia.frame_done;
    end
    chk("fd_seen", {31'b0, hit}, 1);
  endtask
  // entered on the negedge of the first cycle of a frame, leaves on the negedge of its last
  task automatic check_frame(input bit tear);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      if (k > 0) @(negedge clk);
      if (q.size() == 0) begin
        chk("q_empty", 32'(q.size()), 1);
        return;
      end
      e = q.pop_front();
      chk($sformatf("an_k%0d", k), {28'b0, ia.an_n}, {28'b0, e.an});
      chk($sformatf("seg_hex_k%0d", k), {25'b0, ia.seg_n}, {25'b0, e.sa});
      chk($sformatf("seg_dec_k%0d", k), {25'b0, ib.seg_n}, {25'b0, e.sb});
      chk($sformatf("dp_k%0d", k), {31'b0, ia.dp_n}, {31'b0, e.dp});
      chk($sformatf("fd_k%0d", k), {31'b0, ia.frame_done}, {31'b0, e.fd});
      if (tear)
        case (k)
          5: drive(1'b1, 16'h1111, 4'h0, 4'h0);
          9: drive(1'b1, 16'h2222, 4'h0, 4'h0);
          15: begin
            drive(1'b1, 16'h3333, 4'h0, 4'h0);
            push_frame(16'h3333, 4'h0, 4'h0);
          end
          default: drive(1'b0, 16'h0, 4'h0, 4'h0);
        endcase
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'b0, ia.seg_n}, 32'h7F);
    chk("rst_dp", {31'b0, ia.dp_n}, 1);
    chk("rst_an", {28'b0, ia.an_n}, 32'hF);
    chk("rst_fd", {31'b0, ia.frame_done}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("dark_an", {28'b0, ia.an_n}, 32'hF);
      chk("dark_an_c", {31'b0, ic.an_n}, 1);
    end
    drive(1'b1, 16'h3210, 4'h0, 4'h0);
    push_frame(16'h3210, 4'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 16'h3210, 4'h0, 4'h0);
    wait_fd();
    check_frame(1'b0);
    @(negedge clk);
    push_frame(16'h3210, 4'h0, 4'h0);
    check_frame(1'b0);
    begin
      logic hit = 1'b0;
      for (int i = 0; i < 4 && !hit; i++) begin
        @(negedge clk);
        hit = ic.frame_done;
      end
      chk("c_fd_seen", {31'b0, hit}, 1);
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        chk("c_an", {31'b0, ic.an_n}, 0);
        chk("c_fd", {31'b0, ic.frame_done}, (k % 2 == 0) ? 1 : 0);
        chk("c_seg", {25'b0, ic.seg_n}, 32'b0000001);
      end
    end
    drive(1'b1, 16'hFEDA, 4'h0, 4'h0);
    push_frame(16'hFEDA, 4'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 16'hFEDA, 4'h0, 4'h0);
    wait_fd();
    check_frame(1'b0);
    @(negedge clk);
    push_frame(16'hFEDA, 4'h0, 4'h0);
    check_frame(1'b1);
    @(negedge clk);
    drive(1'b0, 16'h3333, 4'h0, 4'h0);
    check_frame(1'b0);
    drive(1'b1, 16'h3210, 4'b0011, 4'b0010);
    push_frame(16'h3210, 4'b0011, 4'b0010);
    @(negedge clk);
    drive(1'b0, 16'h3210, 4'b0011, 4'b0010);
    wait_fd();
    check_frame(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", {25'b0, ia.seg_n}, 32'h7F);
    chk("arst_dp", {31'b0, ia.dp_n}, 1);
    chk("arst_an", {28'b0, ia.an_n}, 32'hF);
    chk("arst_fd", {31'b0, ia.frame_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 16'h5555, 4'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 16'h5555, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("discard_an", {28'b0, ia.an_n}, 32'hF);
    end
    chk("q_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
